// File: rtl/jt51_kon_pkg.sv
// Shared definitions for the YM2151 key-on sequencer: slot width, operator
// groups and the mapping from key-on register mask bits to groups.
package jt51_kon_pkg;

   localparam int SLOT_W = 5;
   localparam logic [SLOT_W-1:0] SLOT_LAST = 5'd31;

   typedef enum logic [1:0] {
      GRP_M1 = 2'd0,
      GRP_M2 = 2'd1,
      GRP_C1 = 2'd2,
      GRP_C2 = 2'd3
   } grp_e;

   // Register 0x08 orders its mask as M1, C1, M2, C2, unlike the slot order.
   function automatic grp_e mask_grp(input logic [1:0] mask_bit);
      grp_e g;
      case (mask_bit)
         2'd0:    g = GRP_M1;
         2'd1:    g = GRP_C1;
         2'd2:    g = GRP_M2;
         default: g = GRP_C2;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/jt51_kon.sv
// Key-on sequencer: tracks requested and current key state per operator slot
// and emits one-cycle keyon/keyoff pulses as each slot is evaluated.
module jt51_kon
   import jt51_kon_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        zero,
   input  logic        kon_we,
   input  logic [2:0]  kon_ch,
   input  logic [3:0]  kon_mask,
   input  logic        csm,
   output logic        keyon,
   output logic        keyoff,
   output logic [4:0]  slot_out
);

   logic [SLOT_W-1:0] r_prev;
   logic [31:0]       r_req;
   logic [31:0]       r_cur;
   logic              r_csm_pend;
   logic              r_csm_frame;
   logic              r_keyon;
   logic              r_keyoff;
   logic [SLOT_W-1:0] r_slot_out;

   logic [SLOT_W-1:0] w_slot;
   logic              w_csm_frame;
   logic              w_target;
   logic              w_cur;

   // Slot 0 is evaluated on the zero cycle itself, so the CSM frame flag must
   // already apply there: it is taken combinationally from the pending bit.
   assign w_slot      = zero ? '0 : r_prev + 5'd1;
   assign w_csm_frame = zero ? r_csm_pend : r_csm_frame;
   assign w_cur       = r_cur[w_slot];
   assign w_target    = w_csm_frame | r_req[w_slot];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev      <= '0;
         r_req       <= '0;
         r_cur       <= '0;
         r_csm_pend  <= 1'b0;
         r_csm_frame <= 1'b0;
         r_keyon     <= 1'b0;
         r_keyoff    <= 1'b0;
         r_slot_out  <= '0;
      end else begin
         r_prev      <= w_slot;
         r_csm_pend  <= csm | (r_csm_pend & ~zero);
         r_csm_frame <= w_csm_frame & (w_slot != SLOT_LAST);

         r_keyon     <= w_target & ~w_cur;
         r_keyoff    <= ~w_target & w_cur;
         r_slot_out  <= w_slot;
         r_cur[w_slot] <= w_target;

         // Evaluation above read the pre-write req; a write to the slot under
         // evaluation only shows at that slot's next visit.
         if (kon_we) begin
            for (int b = 0; b < 4; b++) begin
               r_req[{mask_grp(2'(b)), kon_ch}] <= kon_mask[b];
            end
         end
      end
   end

   assign keyon    = r_keyon;
   assign keyoff   = r_keyoff;
   assign slot_out = r_slot_out;

endmodule

// File: tb/tb_jt51_kon.sv
// Directed bench for jt51_kon: drives the frame marker, key-on writes and
// CSM triggers, and checks pulse counts and slot sets against hand values.
module tb_jt51_kon;

   logic       clk;
   logic       rst;
   logic       zero;
   logic       kon_we;
   logic [2:0] kon_ch;
   logic [3:0] kon_mask;
   logic       csm;
   logic       keyon;
   logic       keyoff;
   logic [4:0] slot_out;

   jt51_kon dut (
      .clk      (clk),
      .rst      (rst),
      .zero     (zero),
      .kon_we   (kon_we),
      .kon_ch   (kon_ch),
      .kon_mask (kon_mask),
      .csm      (csm),
      .keyon    (keyon),
      .keyoff   (keyoff),
      .slot_out (slot_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks;
   int          n_fail;
   logic [4:0]  tb_next;
   int          n_on;
   int          n_off;
   int          n_both;
   logic [31:0] on_mask;
   logic [31:0] off_mask;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_acc();
      n_on     = 0;
      n_off    = 0;
      on_mask  = '0;
      off_mask = '0;
   endtask

   // One clock: drive inputs, take the edge, sample the registered result of
   // the slot evaluated at that edge.
   task automatic cycle(input logic we, input logic [2:0] ch, input logic [3:0] mask, input logic c);
      zero     = (tb_next == 5'd0);
      kon_we   = we;
      kon_ch   = ch;
      kon_mask = mask;
      csm      = c;
      @(posedge clk);
      #1;
      zero    = 1'b0;
      kon_we  = 1'b0;
      csm     = 1'b0;
      tb_next = tb_next + 5'd1;
      if (keyon) begin
         n_on++;
         on_mask[slot_out] = 1'b1;
      end
      if (keyoff) begin
         n_off++;
         off_mask[slot_out] = 1'b1;
      end
      if (keyon && keyoff) n_both++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 4'd0, 1'b0);
   endtask

   task automatic goto_slot(input logic [4:0] s);
      for (int i = 0; i < 32 && tb_next != s; i++) cycle(1'b0, 3'd0, 4'd0, 1'b0);
   endtask

   // Writes and CSM are driven during reset to show they are ignored.
   task automatic do_reset(input string tag);
      rst      = 1'b1;
      zero     = 1'b0;
      kon_we   = 1'b1;
      kon_ch   = 3'd6;
      kon_mask = 4'hf;
      csm      = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      kon_we = 1'b0;
      csm    = 1'b0;
      check_eq({tag, "_keyon"}, 32'(keyon), 32'd0);
      check_eq({tag, "_keyoff"}, 32'(keyoff), 32'd0);
      check_eq({tag, "_slot"}, 32'(slot_out), 32'd0);
      tb_next = 5'd0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_both   = 0;
      tb_next  = 5'd0;
      rst      = 1'b1;
      zero     = 1'b0;
      kon_we   = 1'b0;
      kon_ch   = 3'd0;
      kon_mask = 4'd0;
      csm      = 1'b0;
      clear_acc();
      @(posedge clk);
      do_reset("rst0");

      // Single operator M1 on channel 2.
      clear_acc();
      cycle(1'b1, 3'd2, 4'b0001, 1'b0);
      idle(40);
      check_eq("m1_on_cnt", n_on, 1);
      check_eq("m1_on_slot", on_mask, 32'h0000_0004);
      check_eq("m1_off_cnt", n_off, 0);

      goto_slot(5'd0);
      clear_acc();
      cycle(1'b1, 3'd2, 4'b0000, 1'b0);
      idle(40);
      check_eq("m1_off_cnt2", n_off, 1);
      check_eq("m1_off_slot", off_mask, 32'h0000_0004);
      check_eq("m1_on_cnt2", n_on, 0);

      // All four operators within one frame.
      goto_slot(5'd0);
      clear_acc();
      cycle(1'b1, 3'd2, 4'b1111, 1'b0);
      idle(31);
      check_eq("all_on_cnt", n_on, 4);
      check_eq("all_on_slots", on_mask, 32'h0404_0404);
      clear_acc();
      cycle(1'b1, 3'd2, 4'b0000, 1'b0);
      idle(40);
      check_eq("all_off_cnt", n_off, 4);
      check_eq("all_off_slots", off_mask, 32'h0404_0404);

      // Write lands on the cycle slot 5 is evaluated.
      goto_slot(5'd5);
      clear_acc();
      cycle(1'b1, 3'd5, 4'b0001, 1'b0);
      goto_slot(5'd0);
      check_eq("same_cyc_none", n_on, 0);
      idle(32);
      check_eq("same_cyc_next_cnt", n_on, 1);
      check_eq("same_cyc_next_slot", on_mask, 32'h0000_0020);
      cycle(1'b1, 3'd5, 4'b0000, 1'b0);
      idle(40);

      // On then off before slot 0 is revisited.
      goto_slot(5'd1);
      clear_acc();
      cycle(1'b1, 3'd0, 4'b0001, 1'b0);
      cycle(1'b1, 3'd0, 4'b0000, 1'b0);
      idle(40);
      check_eq("collapse_on", n_on, 0);
      check_eq("collapse_off", n_off, 0);

      // CSM with all requests clear.
      goto_slot(5'd10);
      clear_acc();
      cycle(1'b0, 3'd0, 4'd0, 1'b1);
      goto_slot(5'd0);
      check_eq("csm_wait_on", n_on, 0);
      idle(32);
      check_eq("csm_on_cnt", n_on, 32);
      check_eq("csm_on_slots", on_mask, 32'hffff_ffff);
      clear_acc();
      idle(32);
      check_eq("csm_off_cnt", n_off, 32);
      check_eq("csm_off_slots", off_mask, 32'hffff_ffff);
      check_eq("csm_off_on", n_on, 0);

      // CSM with channel 1 held on.
      clear_acc();
      cycle(1'b1, 3'd1, 4'b1111, 1'b0);
      idle(31);
      check_eq("ch1_on_slots", on_mask, 32'h0202_0202);
      clear_acc();
      cycle(1'b0, 3'd0, 4'd0, 1'b1);
      goto_slot(5'd0);
      idle(32);
      check_eq("csm_held_on_cnt", n_on, 28);
      check_eq("csm_held_on_slots", on_mask, 32'hfdfd_fdfd);
      clear_acc();
      idle(32);
      check_eq("csm_held_off_cnt", n_off, 28);
      check_eq("csm_held_off_slots", off_mask, 32'hfdfd_fdfd);

      // Early frame marker mid-frame.
      goto_slot(5'd13);
      clear_acc();
      tb_next = 5'd0;
      idle(64);
      check_eq("early_zero_on", n_on, 0);
      check_eq("early_zero_off", n_off, 0);

      // Reset mid-frame with channels 1 and 3 keyed on.
      goto_slot(5'd0);
      clear_acc();
      cycle(1'b1, 3'd3, 4'b1111, 1'b0);
      idle(31);
      check_eq("ch3_on_slots", on_mask, 32'h0808_0808);
      idle(7);
      clear_acc();
      do_reset("rst_mid");
      idle(64);
      check_eq("rst_mid_off", n_off, 0);
      check_eq("rst_mid_on", n_on, 0);
      goto_slot(5'd0);
      clear_acc();
      cycle(1'b1, 3'd3, 4'b1111, 1'b0);
      idle(31);
      check_eq("post_rst_on_cnt", n_on, 4);
      check_eq("post_rst_on_slots", on_mask, 32'h0808_0808);

      check_eq("never_both", n_both, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jt51_kon.md
JT51_KON -- requirements
Module: jt51_kon

Interface
REQ-001 clk  in  1  system clock; one operator slot evaluated per cycle.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 zero  in  1  frame marker; high on the cycle slot 0 is evaluated, once every 32 cycles.
REQ-004 kon_we  in  1  single-cycle write strobe for the key-on register (YM2151 reg 0x08).
REQ-005 kon_ch  in  3  channel number of the write.
REQ-006 kon_mask  in  4  operator enables: bit0 M1, bit1 C1, bit2 M2, bit3 C2.
REQ-007 csm  in  1  single-cycle CSM trigger (timer A overflow with CSM enabled).
REQ-008 keyon  out  1  key-on pulse for the slot on slot_out.
REQ-009 keyoff  out  1  key-off pulse for the slot on slot_out.
REQ-010 slot_out  out  5  slot index qualifying keyon/keyoff, encoded {grp[1:0], ch[2:0]}; grp 0=M1, 1=M2, 2=C1, 3=C2.

Function
REQ-011 Evaluation slot counter: 0 on cycles with zero=1, otherwise previous+1, wrapping 31->0.
REQ-012 A write sets req[{grp,ch}] = kon_mask bit of that operator for all four operators of kon_ch; other channels are unchanged.
REQ-013 Per evaluated slot s: target = csm_frame ? 1 : req[s]; target=1 and cur[s]=0 -> keyon, cur[s]<=1; target=0 and cur[s]=1 -> keyoff, cur[s]<=0; otherwise no pulse.
REQ-014 keyon, keyoff and slot_out are registered; each is valid one cycle after its slot is evaluated.
REQ-015 keyon and keyoff shall never both be 1 in the same cycle; each is high for at most one cycle per slot visit.
REQ-016 A write landing in the same cycle as the evaluation of an affected slot takes effect at that slot's next visit; the evaluation uses the pre-write req.
REQ-017 Several writes between two visits of a slot collapse to the last value; an on-then-off sequence within one frame produces no pulse.
REQ-018 csm sets csm_pend; csm_pend converts to csm_frame at the next zero=1 cycle and is cleared at the same time; csm_frame lasts exactly slots 0..31 of that frame.
REQ-019 csm during an active csm_frame re-arms csm_pend for the following frame.
REQ-020 In the frame after a csm_frame, normal rules apply: slots with req=0 emit keyoff, and slots with req=1 emit nothing.
REQ-021 An early zero (counter not at 31) resynchronises the counter to 0 and causes no spurious pulses; a csm_frame in progress ends and csm_pend becomes csm_frame again only if pending.

Reset
REQ-022 Reset clears req, cur, csm_pend, csm_frame and the counter; keyon=0, keyoff=0, slot_out=0 on the cycle after rst.
REQ-023 Reset mid-frame drops all pending and active key states without emitting keyoff; kon_we and csm are ignored while rst=1.

Structure
REQ-024 The shared package holds the slot width (5), the operator group encodings (M1/M2/C1/C2) and the mask-bit-to-group mapping.
REQ-025 req and cur are 32-bit flop vectors indexed by slot; the design is flat, with no sub-module.

Verification
REQ-026 Write ch=2, mask=4'b0001 -> exactly one keyon with slot_out=5'd2 within 33 cycles; no further pulses.
REQ-027 Then write ch=2, mask=0 -> one keyoff with slot_out=5'd2; write ch=2, mask=4'b1111 -> keyon on slots 2, 10, 18, 26 in one frame.
REQ-028 Write ch=5, mask=1 in the same cycle slot 5 is evaluated -> no pulse that frame; keyon on slot 5 in the next frame.
REQ-029 Write ch=0 mask=1 then mask=0 before slot 0 is revisited -> no keyon, no keyoff.
REQ-030 req all 0, pulse csm -> next frame: 32 keyon pulses, slots 0..31; following frame: 32 keyoff pulses. With ch=1 mask=4'b1111 held, slots 1/9/17/25 get no keyoff.
REQ-031 Keyon ch=3 all ops, assert rst for 1 cycle mid-frame -> no keyoff emitted, outputs 0; a new write ch=3 mask=4'b1111 yields 4 keyon.
